// File: rtl/reg_bank_pkg.sv
// Shared encodings for the register bank and its byte-stream loader.
// FunSel operation codes and stream assembler state encodings.
package reg_bank_pkg;

  typedef enum logic [2:0] {
    FS_DEC  = 3'b000,
    FS_INC  = 3'b001,
    FS_LOAD = 3'b010,
    FS_CLR  = 3'b011,
    FS_LDB  = 3'b100,
    FS_LDH  = 3'b101,
    FS_SHB  = 3'b110,
    FS_SXH  = 3'b111
  } funsel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_COMMIT  = 2'b10
  } stream_st_e;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/byte_stream_asm.sv
// Byte-stream assembler: collects WIDTH/8 bytes MSB-first and
// presents one commit cycle for the latched target register.
module byte_stream_asm
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [$clog2(NREGS)-1:0] sel_i,
  input  logic                     abort_i,
  input  logic [BYTE_W-1:0]        byte_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     wr_o,
  output logic [$clog2(NREGS)-1:0] wr_sel_o,
  output logic [WIDTH-1:0]         wr_data_o,
  output logic                     done_o
);

  localparam int NB = WIDTH / BYTE_W;
  localparam int CW = $clog2(NB + 1);
  localparam int SW = $clog2(NREGS);

  stream_st_e     st_q, st_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic           done_q, done_d;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    asm_d  = asm_q;
    sel_d  = sel_q;
    done_d = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (start_i) begin
          st_d  = ST_COLLECT;
          sel_d = sel_i;
          cnt_d = '0;
          asm_d = '0;
        end
      end
      ST_COLLECT: begin
        // abort wins over a byte offered in the same cycle
        if (abort_i) begin
          st_d = ST_IDLE;
        end else if (valid_i) begin
          asm_d = {asm_q[WIDTH-BYTE_W-1:0], byte_i};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(NB - 1)) begin
            st_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        done_d = 1'b1;
        st_d   = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      asm_q  <= '0;
      sel_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      asm_q  <= asm_d;
      sel_q  <= sel_d;
      done_q <= done_d;
    end
  end

  assign ready_o   = (st_q == ST_COLLECT);
  assign wr_o      = (st_q == ST_COMMIT);
  assign wr_sel_o  = sel_q;
  assign wr_data_o = asm_q;
  assign done_o    = done_q;

endmodule

// File: rtl/reg_bank_seq.sv
// Register bank with per-register FunSel operations, two read
// ports and a byte-stream loader that overrides FunSel on commit.
module reg_bank_seq
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [NREGS-1:0]         E,
  input  logic [2:0]               FunSel,
  input  logic [WIDTH-1:0]         I,
  input  logic [$clog2(NREGS)-1:0] OutASel,
  input  logic [$clog2(NREGS)-1:0] OutBSel,
  output logic [WIDTH-1:0]         OutA,
  output logic [WIDTH-1:0]         OutB,
  input  logic                     StreamStart,
  input  logic [$clog2(NREGS)-1:0] StreamSel,
  input  logic                     StreamAbort,
  input  logic [7:0]               ByteIn,
  input  logic                     ByteValid,
  output logic                     ByteReady,
  output logic                     StreamDone,
  output logic                     Wrap
);

  localparam int SW = $clog2(NREGS);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             wrap_q, wrap_d;

  logic             s_wr;
  logic [SW-1:0]    s_sel;
  logic [WIDTH-1:0] s_data;

  byte_stream_asm #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_asm (
    .clk       (Clock),
    .rst_n     (Reset),
    .start_i   (StreamStart),
    .sel_i     (StreamSel),
    .abort_i   (StreamAbort),
    .byte_i    (ByteIn),
    .valid_i   (ByteValid),
    .ready_o   (ByteReady),
    .wr_o      (s_wr),
    .wr_sel_o  (s_sel),
    .wr_data_o (s_data),
    .done_o    (StreamDone)
  );

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [WIDTH-1:0] q
  );
    logic [WIDTH-1:0] r;
    r = q;
    unique case (funsel_e'(FunSel))
      FS_DEC:  r = q - 1'b1;
      FS_INC:  r = q + 1'b1;
      FS_LOAD: r = I;
      FS_CLR:  r = '0;
      FS_LDB:  r = WIDTH'(I[7:0]);
      FS_LDH:  r = WIDTH'(I[15:0]);
      FS_SHB:  r = {q[WIDTH-9:0], I[7:0]};
      FS_SXH:  r = WIDTH'($signed(I[15:0]));
    endcase
    return r;
  endfunction

  always_comb begin
    wrap_d = 1'b0;
    for (int k = 0; k < NREGS; k++) begin
      regs_d[k] = regs_q[k];
      if (s_wr && (s_sel == SW'(k))) begin
        regs_d[k] = s_data;
      end else if (E[k]) begin
        regs_d[k] = apply_op(regs_q[k]);
        if ((FunSel == FS_INC && (&regs_q[k])) ||
            (FunSel == FS_DEC && (regs_q[k] == '0))) begin
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= '0;
      end
      wrap_q <= 1'b0;
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
      wrap_q <= wrap_d;
    end
  end

  assign OutA = regs_q[OutASel];
  assign OutB = regs_q[OutBSel];
  assign Wrap = wrap_q;

endmodule

// File: tb/tb_reg_bank_seq.sv
// Directed bench for reg_bank_seq: FunSel ops, wrap pulses,
// stream load, commit priority, abort and async reset.
module tb_reg_bank_seq;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [3:0]  E;
  logic [2:0]  FunSel;
  logic [31:0] I;
  logic [1:0]  OutASel, OutBSel;
  logic [31:0] OutA, OutB;
  logic        StreamStart;
  logic [1:0]  StreamSel;
  logic        StreamAbort;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady, StreamDone, Wrap;

  int nvec = 0;
  int nmis = 0;

  reg_bank_seq #(.WIDTH(32), .NREGS(4)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .E           (E),
    .FunSel      (FunSel),
    .I           (I),
    .OutASel     (OutASel),
    .OutBSel     (OutBSel),
    .OutA        (OutA),
    .OutB        (OutB),
    .StreamStart (StreamStart),
    .StreamSel   (StreamSel),
    .StreamAbort (StreamAbort),
    .ByteIn      (ByteIn),
    .ByteValid   (ByteValid),
    .ByteReady   (ByteReady),
    .StreamDone  (StreamDone),
    .Wrap        (Wrap)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] sel,
                         input logic [31:0] exp);
    OutASel = sel;
    #1;
    chk(tag, OutA, exp);
  endtask

  task automatic send(input logic [7:0] b);
    ByteValid = 1'b1;
    ByteIn    = b;
    tick();
    ByteValid = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; E = '0; FunSel = '0; I = '0;
    OutASel = '0; OutBSel = '0;
    StreamStart = 1'b0; StreamSel = '0; StreamAbort = 1'b0;
    ByteIn = '0; ByteValid = 1'b0;
    tick(); tick();
    chk_reg("rst_r0", 2'd0, 32'h0);
    chk_reg("rst_r3", 2'd3, 32'h0);
    chk("rst_ready", {31'b0, ByteReady}, 32'h0);
    chk("rst_done", {31'b0, StreamDone}, 32'h0);
    chk("rst_wrap", {31'b0, Wrap}, 32'h0);
    Reset = 1'b1;
    tick();

    // decrement from zero wraps
    E = 4'b0001; FunSel = 3'b000;
    tick();
    E = '0;
    chk_reg("dec_r0", 2'd0, 32'hFFFF_FFFF);
    chk("dec_wrap", {31'b0, Wrap}, 32'h1);
    OutBSel = 2'd1; #1;
    chk("dec_r1", OutB, 32'h0);
    tick();
    chk("dec_wrap_end", {31'b0, Wrap}, 32'h0);

    // increment from all-ones wraps
    E = 4'b0001; FunSel = 3'b001;
    tick();
    E = '0;
    chk_reg("inc_r0", 2'd0, 32'h0);
    chk("inc_wrap", {31'b0, Wrap}, 32'h1);

    E = 4'b0110; FunSel = 3'b111; I = 32'h0000_8001;
    tick();
    chk_reg("sxh_r1", 2'd1, 32'hFFFF_8001);
    chk_reg("sxh_r2", 2'd2, 32'hFFFF_8001);
    chk("sxh_nowrap", {31'b0, Wrap}, 32'h0);
    FunSel = 3'b110; I = 32'h0000_00AB;
    tick();
    E = '0;
    chk_reg("shb_r1", 2'd1, 32'hFF80_01AB);
    chk_reg("shb_r2", 2'd2, 32'hFF80_01AB);
    chk_reg("shb_r0", 2'd0, 32'h0);

    E = 4'b0001; FunSel = 3'b010; I = 32'h1234_5678;
    tick();
    chk_reg("load_r0", 2'd0, 32'h1234_5678);
    FunSel = 3'b100;
    tick();
    chk_reg("ldb_r0", 2'd0, 32'h0000_0078);
    FunSel = 3'b101;
    tick();
    chk_reg("ldh_r0", 2'd0, 32'h0000_5678);
    E = '0; FunSel = 3'b011;
    tick();
    chk_reg("hold_r0", 2'd0, 32'h0000_5678);
    E = 4'b0001;
    tick();
    E = '0;
    chk_reg("clr_r0", 2'd0, 32'h0);

    // stream to R3 with gapped ByteValid
    StreamStart = 1'b1; StreamSel = 2'd3;
    tick();
    StreamStart = 1'b0;
    chk("s3_ready", {31'b0, ByteReady}, 32'h1);
    tick(); send(8'h12);
    tick(); send(8'h34);
    tick(); send(8'h56);
    tick(); send(8'h78);
    chk("s3_ready_off", {31'b0, ByteReady}, 32'h0);
    chk("s3_done_early", {31'b0, StreamDone}, 32'h0);
    tick();
    chk("s3_done", {31'b0, StreamDone}, 32'h1);
    chk_reg("s3_r3", 2'd3, 32'h1234_5678);
    tick();
    chk("s3_done_end", {31'b0, StreamDone}, 32'h0);

    // stream to R2; FunSel in commit cycle loses on R2 only
    StreamStart = 1'b1; StreamSel = 2'd2;
    tick();
    StreamSel = 2'd0;
    send(8'hCA);
    StreamStart = 1'b0;
    send(8'hFE); send(8'hBA); send(8'hBE);
    E = 4'b0101; FunSel = 3'b010; I = 32'hDEAD_BEEF;
    tick();
    E = '0;
    chk_reg("pri_r2", 2'd2, 32'hCAFE_BABE);
    chk_reg("pri_r0", 2'd0, 32'hDEAD_BEEF);
    chk_reg("pri_r3", 2'd3, 32'h1234_5678);
    tick();

    // abort after two bytes, then a full stream to R1
    StreamStart = 1'b1; StreamSel = 2'd1;
    tick();
    StreamStart = 1'b0;
    send(8'h11); send(8'h22);
    StreamAbort = 1'b1;
    tick();
    StreamAbort = 1'b0;
    chk("ab_ready", {31'b0, ByteReady}, 32'h0);
    chk_reg("ab_r1", 2'd1, 32'hFF80_01AB);
    tick();
    chk("ab_nodone", {31'b0, StreamDone}, 32'h0);
    StreamStart = 1'b1;
    tick();
    StreamStart = 1'b0;
    send(8'h01);
    E = 4'b0010; FunSel = 3'b001;
    tick();
    E = '0;
    chk_reg("mid_inc_r1", 2'd1, 32'hFF80_01AC);
    send(8'h02); send(8'h03); send(8'h04);
    tick();
    chk("s1_done", {31'b0, StreamDone}, 32'h1);
    chk_reg("s1_r1", 2'd1, 32'h0102_0304);
    tick();

    // asynchronous reset mid-stream
    StreamStart = 1'b1; StreamSel = 2'd0;
    tick();
    StreamStart = 1'b0;
    send(8'hAA); send(8'hBB); send(8'hCC);
    chk("ar_ready_pre", {31'b0, ByteReady}, 32'h1);
    #2;
    Reset = 1'b0;
    #1;
    chk("ar_ready", {31'b0, ByteReady}, 32'h0);
    chk_reg("ar_r0", 2'd0, 32'h0);
    chk_reg("ar_r3", 2'd3, 32'h0);
    tick();
    Reset = 1'b1;
    send(8'hDD);
    tick();
    chk("ar_nodone", {31'b0, StreamDone}, 32'h0);
    chk_reg("ar_r0_after", 2'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/reg_bank_seq.md
REG_BANK_SEQ -- requirements
Module: reg_bank_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, register width in bits (multiple of 8, 16..64).
REQ-002 The block SHALL have parameter NREGS, default 4, number of registers (2..16).
REQ-003 The block SHALL have port Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port E  input  NREGS  per-register enable for FunSel operations.
REQ-006 The block SHALL have port FunSel  input  3  operation applied to every enabled register.
REQ-007 The block SHALL have port I  input  WIDTH  data operand.
REQ-008 The block SHALL have ports OutASel, OutBSel  input  clog2(NREGS)  read-port selects.
REQ-009 The block SHALL have ports OutA, OutB  output  WIDTH  combinational read of the selected registers.
REQ-010 The block SHALL have ports StreamStart (input 1), StreamSel (input clog2(NREGS)), StreamAbort (input 1): byte-stream load control.
REQ-011 The block SHALL have ports ByteIn (input 8), ByteValid (input 1), ByteReady (output 1): byte handshake.
REQ-012 The block SHALL have ports StreamDone (output 1) and Wrap (output 1), both single-cycle registered pulses.

Function
REQ-013 FunSel SHALL encode, per enabled register Q: 000 Q-1 mod 2^WIDTH; 001 Q+1 mod 2^WIDTH; 010 I; 011 zero; 100 zero-extended I[7:0]; 101 zero-extended I[15:0]; 110 {Q[WIDTH-9:0], I[7:0]}; 111 sign-extended I[15:0].
REQ-014 Registers with E bit low SHALL hold; FunSel SHALL have no effect when E is all zero.
REQ-015 Wrap SHALL pulse the cycle after any enabled register incremented from all-ones or decremented from zero.
REQ-016 The stream FSM SHALL have states IDLE, COLLECT, COMMIT.
REQ-017 IDLE->COLLECT on StreamStart; StreamSel SHALL be latched, byte counter and assembly buffer cleared.
REQ-018 ByteReady SHALL be high only in COLLECT; a byte SHALL be accepted on cycles where ByteValid and ByteReady are both high.
REQ-019 Accepted bytes SHALL be shifted in MSB-first (first byte ends in bits WIDTH-1:WIDTH-8).
REQ-020 After the WIDTH/8-th accepted byte the FSM SHALL enter COMMIT; counter SHALL not wrap or exceed WIDTH/8.
REQ-021 In COMMIT the buffer SHALL be written to the latched register, StreamDone SHALL pulse the following cycle, FSM SHALL return to IDLE.
REQ-022 In the COMMIT cycle the stream write SHALL take priority over FunSel on the same register; FunSel on other registers SHALL proceed.
REQ-023 StreamStart SHALL be ignored outside IDLE.
REQ-024 StreamAbort in COLLECT SHALL return to IDLE with no register write and no StreamDone; it SHALL be ignored in COMMIT and IDLE.
REQ-025 FunSel operations SHALL remain available on all registers while a stream is in progress, including the target register before COMMIT.

Reset
REQ-026 Reset low SHALL immediately clear all registers, assembly buffer and counter to zero, force FSM to IDLE, and drive ByteReady, StreamDone, Wrap low.
REQ-027 Reset asserted mid-stream SHALL discard the partial stream with no write.

Structure
REQ-028 FunSel encodings and FSM state encodings SHALL live in a shared package reg_bank_pkg.
REQ-029 The stream assembler (FSM, counter, buffer, handshake) SHALL be a sub-module byte_stream_asm; the register array and FunSel logic SHALL stay in reg_bank_seq.

Verification
REQ-030 Reset, then E=0001, FunSel=000 one cycle -> R0=0xFFFFFFFF, Wrap pulses next cycle; other registers 0.
REQ-031 E=0110, I=0x0000_8001, FunSel=111 -> R1=R2=0xFFFF8001; then FunSel=110, I=0x0000_00AB -> R1=R2=0xFF8001AB.
REQ-032 StreamStart, StreamSel=3, bytes 0x12,0x34,0x56,0x78 with ByteValid gapped every other cycle -> R3=0x12345678, StreamDone one pulse, ByteReady low after 4th byte.
REQ-033 Stream to R2 with E=0100, FunSel=010, I=0xDEADBEEF asserted in COMMIT cycle -> R2 holds streamed value, not 0xDEADBEEF.
REQ-034 StreamAbort after 2 bytes, then new StreamStart with 4 bytes -> only second stream value written; no StreamDone for first.
REQ-035 Reset pulsed low asynchronously after 3 bytes -> all registers 0, FSM IDLE, ByteReady low before next Clock edge.
